// File: rtl/handshake_rx_multi.sv
// Multi-channel req/ack receive endpoint: synchronises foreign requests and hands bundled
// data to a local valid/ready consumer, acknowledging only after acceptance.
module handshake_rx_multi #(
    parameter int CH   = 4,
    parameter int DW   = 8,
    parameter int SYNC = 2,
    parameter int MODE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CH-1:0]      req_async,
    input  logic [CH*DW-1:0]   data_async,
    output logic [CH-1:0]      ack,
    output logic [CH-1:0]      evt_valid,
    output logic [CH*DW-1:0]   evt_data,
    input  logic [CH-1:0]      evt_ready,
    output logic [CH-1:0]      err,
    input  logic [CH-1:0]      err_clr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VALID  = 2'd1,
        ACK_HI = 2'd2
    } state_t;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            logic [SYNC-1:0] sync_reg;
            logic            req_s;
            logic            req_d_reg;
            state_t          state_reg, state_next;
            logic            ack_reg, ack_next;
            logic            valid_reg;
            logic            err_reg, err_next;
            logic [DW-1:0]   data_reg;
            logic            load;
            logic            violation;

            assign req_s = sync_reg[SYNC-1];

            always_comb begin
                state_next = state_reg;
                ack_next   = ack_reg;
                load       = 1'b0;
                violation  = 1'b0;
                case (state_reg)
                    IDLE: begin
                        // Level mode waits for req high; toggle mode waits for req to differ from ack.
                        if ((MODE == 0) ? req_s : (req_s != ack_reg)) begin
                            load       = 1'b1;
                            state_next = VALID;
                        end
                    end
                    VALID: begin
                        if (MODE == 0) violation = ~req_s;
                        else           violation = (req_s != req_d_reg);
                        if (evt_ready[gi]) begin
                            if (MODE == 0) begin
                                ack_next   = 1'b1;
                                state_next = ACK_HI;
                            end else begin
                                ack_next   = ~ack_reg;
                                state_next = IDLE;
                            end
                        end
                    end
                    ACK_HI: begin
                        if (!req_s) begin
                            ack_next   = 1'b0;
                            state_next = IDLE;
                        end
                    end
                    default: state_next = IDLE;
                endcase
                // A fresh violation outranks a clear arriving in the same cycle.
                err_next = violation ? 1'b1 : (err_clr[gi] ? 1'b0 : err_reg);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg  <= '0;
                    req_d_reg <= 1'b0;
                    state_reg <= IDLE;
                    ack_reg   <= 1'b0;
                    valid_reg <= 1'b0;
                    err_reg   <= 1'b0;
                    data_reg  <= '0;
                end else begin
                    sync_reg  <= {sync_reg[SYNC-2:0], req_async[gi]};
                    req_d_reg <= req_s;
                    state_reg <= state_next;
                    ack_reg   <= ack_next;
                    valid_reg <= (state_next == VALID);
                    err_reg   <= err_next;
                    if (load) data_reg <= data_async[gi*DW +: DW];
                end
            end

            assign ack[gi]                = ack_reg;
            assign evt_valid[gi]          = valid_reg;
            assign err[gi]                = err_reg;
            assign evt_data[gi*DW +: DW]  = data_reg;
        end
    endgenerate

endmodule
